// File: rtl/exec_sequencer_pkg.sv
// Shared types for the execute sequencer.
// Holds the FSM state encoding and ALU opcode width.
package exec_sequencer_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } exec_seq_state_t;

endpackage

// File: rtl/exec_sequencer_lane_mask_gen.sv
// Tail-pass lane mask generator.
// Full mask unless last pass with a nonzero remainder.
module lane_mask_gen #(
  parameter int VECTOR_SIZE = 8,
  parameter int REM_W       = $clog2(VECTOR_SIZE)
) (
  input  logic [REM_W-1:0]       rem,
  input  logic                   last,
  output logic [VECTOR_SIZE-1:0] mask
);

  // lane i enabled when below remainder, or pass is not a short tail
  always_comb begin
    mask = '1;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if (last && (rem != '0) && (i >= int'(rem)))
        mask[i] = 1'b0;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute sequencer: splits a vector command into passes.
// One pass per VECTOR_SIZE lanes, tail pass masked.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int VECTOR_SIZE = 8,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_CTRL_W-1:0]  cmd_alu_control,
  input  logic                   cmd_scalar,
  input  logic [LEN_WIDTH-1:0]   cmd_length,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [ALU_CTRL_W-1:0]  issue_alu_control,
  output logic                   issue_use_scalar_alu,
  output logic [LEN_WIDTH-1:0]   issue_chunk,
  output logic [VECTOR_SIZE-1:0] issue_lane_mask,
  output logic                   issue_last,
  output logic                   done,
  output logic                   busy
);

  localparam int LOG2 = $clog2(VECTOR_SIZE);

  if (WIDTH < 1 || VECTOR_SIZE < 2 ||
      (VECTOR_SIZE & (VECTOR_SIZE - 1)) != 0) begin : g_bad_params
    $error("exec_sequencer: illegal WIDTH/VECTOR_SIZE");
  end

  exec_seq_state_t       state_q, state_d;
  logic [ALU_CTRL_W-1:0] alu_q, alu_d;
  logic                  sc_q, sc_d;
  logic [LOG2-1:0]       rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  npass_q, npass_d;
  logic [LEN_WIDTH-1:0]  chunk_q, chunk_d;

  logic                   in_issue;
  logic                   last;
  logic [LEN_WIDTH-1:0]   vec_passes;
  logic [VECTOR_SIZE-1:0] tail_mask;

  assign in_issue   = (state_q == S_ISSUE);
  assign last       = in_issue &&
                      (chunk_q == npass_q - LEN_WIDTH'(1));
  assign vec_passes = (cmd_length >> LOG2) +
                      LEN_WIDTH'(|cmd_length[LOG2-1:0]);

  lane_mask_gen #(
    .VECTOR_SIZE(VECTOR_SIZE),
    .REM_W      (LOG2)
  ) u_mask (
    .rem (rem_q),
    .last(last && !sc_q),
    .mask(tail_mask)
  );

  // next-state and latched command fields
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    sc_d    = sc_q;
    rem_d   = rem_q;
    npass_d = npass_q;
    chunk_d = chunk_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          alu_d   = cmd_alu_control;
          sc_d    = cmd_scalar;
          rem_d   = cmd_length[LOG2-1:0];
          npass_d = cmd_scalar ? LEN_WIDTH'(1) : vec_passes;
          chunk_d = '0;
          if (!cmd_scalar && cmd_length == '0)
            state_d = S_DONE;
          else
            state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          if (last) begin
            state_d = S_DONE;
            chunk_d = '0;
          end else begin
            chunk_d = chunk_q + LEN_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alu_q   <= '0;
      sc_q    <= 1'b0;
      rem_q   <= '0;
      npass_q <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      sc_q    <= sc_d;
      rem_q   <= rem_d;
      npass_q <= npass_d;
      chunk_q <= chunk_d;
    end
  end

  assign cmd_ready            = (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_DONE);
  assign issue_valid          = in_issue;
  assign issue_last           = last;
  assign issue_chunk          = chunk_q;
  assign issue_alu_control    = alu_q;
  assign issue_use_scalar_alu = sc_q;
  assign issue_lane_mask      = in_issue ? tail_mask : '0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer.
// Hand-computed pass counts, chunks and masks.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_alu_control;
  logic       cmd_scalar;
  logic [7:0] cmd_length;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_alu_control;
  logic       issue_use_scalar_alu;
  logic [7:0] issue_chunk;
  logic [7:0] issue_lane_mask;
  logic       issue_last;
  logic       done;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  exec_sequencer #(
    .WIDTH(8), .VECTOR_SIZE(8), .LEN_WIDTH(8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_alu_control     (cmd_alu_control),
    .cmd_scalar          (cmd_scalar),
    .cmd_length          (cmd_length),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_alu_control   (issue_alu_control),
    .issue_use_scalar_alu(issue_use_scalar_alu),
    .issue_chunk         (issue_chunk),
    .issue_lane_mask     (issue_lane_mask),
    .issue_last          (issue_last),
    .done                (done),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sc, input logic [3:0] alu,
                      input logic [7:0] len);
    chk("ready_before", cmd_ready, 1);
    cmd_valid       = 1'b1;
    cmd_scalar      = sc;
    cmd_alu_control = alu;
    cmd_length      = len;
    step();
    cmd_valid       = 1'b0;
    cmd_scalar      = ~sc;
    cmd_alu_control = ~alu;
    cmd_length      = ~len;
  endtask

  task automatic run(input string tag, input int n,
                     input logic [7:0] lmask, input bit sc,
                     input logic [3:0] alu);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_valid"}, issue_valid, 1);
      chk({tag, "_chunk"}, issue_chunk, k);
      chk({tag, "_last"}, issue_last, (k == n - 1));
      chk({tag, "_mask"}, issue_lane_mask,
          (k == n - 1) ? lmask : 8'hFF);
      chk({tag, "_alu"}, issue_alu_control, alu);
      chk({tag, "_sc"}, issue_use_scalar_alu, sc);
      chk({tag, "_busy"}, busy, 1);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_nvalid"}, issue_valid, 0);
    chk({tag, "_dchunk"}, issue_chunk, 0);
    step();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle_rdy"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, cmd_ready, 1);
    chk({tag, "_valid"}, issue_valid, 0);
    chk({tag, "_last"}, issue_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_chunk"}, issue_chunk, 0);
    chk({tag, "_mask"}, issue_lane_mask, 0);
    chk({tag, "_alu"}, issue_alu_control, 0);
    chk({tag, "_sc"}, issue_use_scalar_alu, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    cmd_scalar      = 1'b0;
    cmd_alu_control = 4'h0;
    cmd_length      = 8'd0;
    issue_ready     = 1'b1;
    #2;
    chk_reset("rst");
    step();
    rst_n = 1'b1;
    step();
    chk_reset("post_rst");

    send(1'b0, 4'h1, 8'd8);
    run("len8", 1, 8'hFF, 1'b0, 4'h1);

    send(1'b0, 4'h2, 8'd19);
    run("len19", 3, 8'h07, 1'b0, 4'h2);

    send(1'b0, 4'h6, 8'd0);
    chk("len0_valid", issue_valid, 0);
    chk("len0_done", done, 1);
    step();
    chk("len0_done_off", done, 0);
    chk("len0_rdy", cmd_ready, 1);

    send(1'b1, 4'h3, 8'd200);
    run("scalar", 1, 8'hFF, 1'b1, 4'h3);

    send(1'b0, 4'h9, 8'd255);
    run("len255", 32, 8'h7F, 1'b0, 4'h9);

    send(1'b0, 4'h4, 8'd16);
    chk("stall_c0", issue_chunk, 0);
    step();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", issue_valid, 1);
      chk("stall_chunk", issue_chunk, 1);
      chk("stall_mask", issue_lane_mask, 8'hFF);
      chk("stall_last", issue_last, 1);
      chk("stall_alu", issue_alu_control, 4'h4);
      chk("stall_done", done, 0);
    end
    issue_ready = 1'b1;
    step();
    chk("stall_fin_done", done, 1);
    chk("stall_fin_valid", issue_valid, 0);
    step();

    send(1'b0, 4'hA, 8'd40);
    chk("rst40_c0", issue_chunk, 0);
    step();
    chk("rst40_c1", issue_chunk, 1);
    step();
    chk("rst40_c2", issue_chunk, 2);
    chk("rst40_alu", issue_alu_control, 4'hA);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    step();
    chk("mid_rst_nodone", done, 0);
    rst_n = 1'b1;
    step();
    chk("rel_nodone", done, 0);
    chk("rel_rdy", cmd_ready, 1);

    send(1'b0, 4'h5, 8'd3);
    run("after_rst", 1, 8'h07, 1'b0, 4'h5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
